// File: rtl/fifo_ptr_ctrl_if.sv
// Handshake and status bundle between a FIFO pointer controller and its user.
// The controller owns the slave side; the requester/observer owns the master side.
interface fifo_ptr_ctrl_if #(
   parameter int ADDR_WIDTH = 2,
   parameter int CNT_WIDTH  = 3
);
   logic                  push;
   logic                  pop;
   logic                  clear;
   logic                  err_clr;
   logic                  write_en;
   logic                  read_en;
   logic [ADDR_WIDTH-1:0] write_addr;
   logic [ADDR_WIDTH-1:0] read_addr;
   logic [CNT_WIDTH-1:0]  count;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output push, pop, clear, err_clr,
      input  write_en, read_en, write_addr, read_addr, count,
      input  full, empty, almost_full, almost_empty, overflow, underflow
   );

   modport slave (
      input  push, pop, clear, err_clr,
      output write_en, read_en, write_addr, read_addr, count,
      output full, empty, almost_full, almost_empty, overflow, underflow
   );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and status controller for a FIFO built on an external dual-port RAM.
// Depth need not be a power of two; pointers wrap explicitly at MEM_DEPTH-1.
module fifo_ptr_ctrl #(
   parameter int MEM_DEPTH  = 4,
   parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
   parameter int CNT_WIDTH  = $clog2(MEM_DEPTH + 1),
   parameter int AF_LEVEL   = MEM_DEPTH - 1,
   parameter int AE_LEVEL   = 1
) (
   input logic           clk,
   input logic           reset,
   fifo_ptr_ctrl_if.slave bus
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
   localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT = CNT_WIDTH'(MEM_DEPTH);
   localparam logic [CNT_WIDTH-1:0]  AF_CNT    = CNT_WIDTH'(AF_LEVEL);
   localparam logic [CNT_WIDTH-1:0]  AE_CNT    = CNT_WIDTH'(AE_LEVEL);

   logic [ADDR_WIDTH-1:0] write_addr_nxt, read_addr_nxt;
   logic [CNT_WIDTH-1:0]  count_nxt;
   logic                  overflow_nxt, underflow_nxt;

   // Requests are ignored during reset and flush; rejection uses the registered flags.
   assign bus.write_en = bus.push & ~bus.full  & ~bus.clear & ~reset;
   assign bus.read_en  = bus.pop  & ~bus.empty & ~bus.clear & ~reset;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      write_addr_nxt = bus.write_addr;
      read_addr_nxt  = bus.read_addr;
      count_nxt      = bus.count;
      overflow_nxt   = bus.overflow & ~bus.err_clr;
      underflow_nxt  = bus.underflow & ~bus.err_clr;

      if (bus.clear) begin
         write_addr_nxt = '0;
         read_addr_nxt  = '0;
         count_nxt      = '0;
      end else begin
         if (bus.write_en)
            write_addr_nxt = (bus.write_addr == LAST_ADDR) ? '0 : bus.write_addr + ADDR_WIDTH'(1);
         if (bus.read_en)
            read_addr_nxt = (bus.read_addr == LAST_ADDR) ? '0 : bus.read_addr + ADDR_WIDTH'(1);
         if (bus.write_en && !bus.read_en)
            count_nxt = bus.count + CNT_WIDTH'(1);
         else if (bus.read_en && !bus.write_en)
            count_nxt = bus.count - CNT_WIDTH'(1);
         // A new error event outranks err_clr in the same cycle.
         if (bus.push && bus.full)
            overflow_nxt = 1'b1;
         if (bus.pop && bus.empty)
            underflow_nxt = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.write_addr   <= '0;
         bus.read_addr    <= '0;
         bus.count        <= '0;
         bus.full         <= 1'b0;
         bus.empty        <= 1'b1;
         bus.almost_full  <= 1'b0;
         bus.almost_empty <= 1'b1;
         bus.overflow     <= 1'b0;
         bus.underflow    <= 1'b0;
      end else begin
         bus.write_addr   <= write_addr_nxt;
         bus.read_addr    <= read_addr_nxt;
         bus.count        <= count_nxt;
         bus.full         <= (count_nxt == DEPTH_CNT);
         bus.empty        <= (count_nxt == '0);
         bus.almost_full  <= (count_nxt >= AF_CNT);
         bus.almost_empty <= (count_nxt <= AE_CNT);
         bus.overflow     <= overflow_nxt;
         bus.underflow    <= underflow_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench for fifo_ptr_ctrl at depth 5: directed corner cases, then
// randomized traffic compared against an occupancy/pointer reference model.
module tb_fifo_ptr_ctrl;

   localparam int DEPTH = 5;
   localparam int AF    = 4;
   localparam int AE    = 1;
   localparam int AW    = 3;
   localparam int CW    = 3;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   // reference model state
   int m_cnt, m_wa, m_ra;
   bit m_ovf, m_unf;

   fifo_ptr_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

   fifo_ptr_ctrl #(
      .MEM_DEPTH (DEPTH),
      .AF_LEVEL  (AF),
      .AE_LEVEL  (AE)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      check("write_addr",   32'(bus.write_addr),   32'(m_wa));
      check("read_addr",    32'(bus.read_addr),    32'(m_ra));
      check("count",        32'(bus.count),        32'(m_cnt));
      check("full",         32'(bus.full),         32'(m_cnt == DEPTH));
      check("empty",        32'(bus.empty),        32'(m_cnt == 0));
      check("almost_full",  32'(bus.almost_full),  32'(m_cnt >= AF));
      check("almost_empty", 32'(bus.almost_empty), 32'(m_cnt <= AE));
      check("overflow",     32'(bus.overflow),     32'(m_ovf));
      check("underflow",    32'(bus.underflow),    32'(m_unf));
   endtask

   // One clock cycle: drive at negedge, check handshake, apply edge, check registered state.
   task automatic step(input bit p, input bit po, input bit c, input bit e, input bit r);
      bit we, re;
      @(negedge clk);
      bus.push    = p;
      bus.pop     = po;
      bus.clear   = c;
      bus.err_clr = e;
      reset       = r;
      #1;
      we = !r && !c && p  && (m_cnt != DEPTH);
      re = !r && !c && po && (m_cnt != 0);
      check("write_en", 32'(bus.write_en), 32'(we));
      check("read_en",  32'(bus.read_en),  32'(re));
      @(posedge clk);
      if (r) begin
         m_cnt = 0; m_wa = 0; m_ra = 0; m_ovf = 0; m_unf = 0;
      end else if (c) begin
         m_cnt = 0; m_wa = 0; m_ra = 0;
         if (e) begin m_ovf = 0; m_unf = 0; end
      end else begin
         bit ov_ev, un_ev;
         ov_ev = p  && (m_cnt == DEPTH);
         un_ev = po && (m_cnt == 0);
         if (e) begin m_ovf = 0; m_unf = 0; end
         if (ov_ev) m_ovf = 1;
         if (un_ev) m_unf = 1;
         m_wa  = (m_wa + int'(we)) % DEPTH;
         m_ra  = (m_ra + int'(re)) % DEPTH;
         m_cnt = m_cnt + int'(we) - int'(re);
      end
      #1;
      check_state();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      m_cnt = 0; m_wa = 0; m_ra = 0; m_ovf = 0; m_unf = 0;
      bus.push = 1'b0; bus.pop = 1'b0; bus.clear = 1'b0; bus.err_clr = 1'b0;
      reset = 1'b1;

      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      check("rst_empty", 32'(bus.empty), 32'd1);
      check("rst_ae",    32'(bus.almost_empty), 32'd1);

      // Fill to full, watching the write address and almost_full threshold.
      for (int i = 0; i < DEPTH; i++) begin
         step(1, 0, 0, 0, 0);
         check("fill_waddr", 32'(bus.write_addr), 32'((i + 1) % DEPTH));
         if (i == 3) begin
            check("fill_af_at4",   32'(bus.almost_full), 32'd1);
            check("fill_full_at4", 32'(bus.full),        32'd0);
         end
      end
      check("fill_full", 32'(bus.full), 32'd1);
      step(1, 0, 0, 0, 0);
      check("ovf_set",   32'(bus.overflow),   32'd1);
      check("ovf_waddr", 32'(bus.write_addr), 32'd0);

      // Drain to empty, then one extra pop.
      for (int i = 0; i < DEPTH; i++) begin
         step(0, 1, 0, 0, 0);
         if (i == 3) check("drain_ae_at1", 32'(bus.almost_empty), 32'd1);
      end
      check("drain_raddr", 32'(bus.read_addr), 32'd0);
      check("drain_empty", 32'(bus.empty),     32'd1);
      step(0, 1, 0, 0, 0);
      check("unf_set", 32'(bus.underflow), 32'd1);
      step(0, 0, 0, 1, 0);
      check("errclr_ovf", 32'(bus.overflow), 32'd0);

      // Steady state at count 2 with simultaneous push and pop.
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0);
      check("steady_count", 32'(bus.count),      32'd2);
      check("steady_waddr", 32'(bus.write_addr), 32'd2);
      check("steady_raddr", 32'(bus.read_addr),  32'd0);

      // Push+pop while full: push rejected, pop accepted.
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      check("fullpp_count", 32'(bus.count),    32'd4);
      check("fullpp_ovf",   32'(bus.overflow), 32'd1);

      // Push+pop while empty: push accepted, pop rejected.
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      check("emptypp_count", 32'(bus.count),     32'd1);
      check("emptypp_unf",   32'(bus.underflow), 32'd1);

      // Flush at count 3 keeps the sticky flags; err_clr then drops them.
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      check("clear_count", 32'(bus.count),    32'd0);
      check("clear_waddr", 32'(bus.write_addr), 32'd0);
      check("clear_ovf",   32'(bus.overflow), 32'd1);
      step(0, 0, 0, 1, 0);
      check("clear_errclr", 32'(bus.overflow), 32'd0);

      // err_clr coinciding with a fresh underflow: the set wins.
      step(0, 1, 0, 1, 0);
      check("setwins_unf", 32'(bus.underflow), 32'd1);

      // Reset mid-operation with push held high.
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1);
      check("midrst_count", 32'(bus.count),     32'd0);
      check("midrst_unf",   32'(bus.underflow), 32'd0);

      // Randomized traffic: push-biased, then pop-biased, then balanced.
      for (int i = 0; i < 600; i++) begin
         int pp, pq;
         pp = (i < 200) ? 75 : (i < 400) ? 30 : 55;
         pq = (i < 200) ? 30 : (i < 400) ? 75 : 55;
         step($urandom_range(99) < pp,
              $urandom_range(99) < pq,
              $urandom_range(59) == 0,
              $urandom_range(11) == 0,
              $urandom_range(149) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
